fios_final_reduce: RTL and testbench
====================================

Name: fios_final_reduce

Overview:
- Downstream of the last PE in the FIOS cascade.
- Captures the 17-bit result words streamed out of the cascade, least-significant word (LSW) first, plus one final carry word. In the same pass it computes T − p word-serially.
- Applies the final conditional subtraction of Montgomery multiplication, then releases the reduced N-word result over a valid/ready stream.

Parameters:
- WIDTH, 17, word width; matches the DSP multiplier operand width.
- N, 16, number of result words per operand. The block captures N+1 words; the last one is the carry word.
- CW, clog2(N+1), width of the internal word counter.

Ports:
- clock_i, input, 1, system clock.
- reset_i, input, 1, synchronous, active-high reset.
- start_i, input, 1, arms capture of a new result. Also clears overrun_o.
- res_valid_i, input, 1, res_i and p_i carry a valid word this cycle. No backpressure is possible on this input.
- res_i, input, WIDTH, result word T[k] from the cascade, LSW first; k = 0..N.
- p_i, input, WIDTH, modulus word p[k], aligned with res_i. Ignored when k = N (p[N] is treated as 0).
- out_valid_o, output, 1, out_data_o is valid.
- out_ready_i, input, 1, consumer accepts the word.
- out_data_o, output, WIDTH, reduced result word, LSW first.
- out_last_o, output, 1, marks word N−1.
- busy_o, output, 1, high in COLLECT or OUTPUT.
- overrun_o, output, 1, sticky. Set when a word arrives outside COLLECT.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: out_valid_o=0, out_data_o=0, out_last_o=0, busy_o=0, overrun_o=0. State=IDLE, counter=0, borrow=0.
- FSM states:
  - IDLE: start_i → COLLECT, with counter=0 and borrow=0. Any res_valid_i seen here sets overrun_o and the word is dropped.
  - COLLECT: each res_valid_i cycle:
    - stores T[k] in buffer T_buf[k];
    - computes {b', D[k]} = T[k] − p[k] − borrow, over WIDTH+1 bits;
    - stores D[k] in D_buf[k] for k < N;
    - sets borrow ← b' and counter ← k+1.
    - On word k=N: latch sel_D = ~b', where b' is the final borrow (sel_D = 1 means T ≥ p). Then go to OUTPUT with counter=0.
  - OUTPUT: out_data_o = sel_D ? D_buf[counter] : T_buf[counter], with out_valid_o=1 and out_last_o = (counter==N−1).
    - A word transfers when out_valid_o && out_ready_i; counter then increments.
    - Transfer of the last word → IDLE; out_valid_o drops on the next cycle.
    - res_valid_i here sets overrun_o; buffers are unaffected.
- Latency: out_valid_o rises on the 1st cycle after the clock edge that captured word N.
- Sustained rate: 1 word/cycle while out_ready_i is held high.
- Output is registered. It is held stable while out_valid_o && !out_ready_i.
- start_i is ignored in COLLECT and OUTPUT. In IDLE it also clears overrun_o. If start_i and res_valid_i are both high in IDLE, the word is dropped and overrun_o is cleared; clearing takes priority.
- The T < 2p precondition is not checked. For any T, the selection rule is exactly sel_D = (final borrow == 0), and the final D[N] word is discarded.
- reset_i mid-COLLECT or mid-OUTPUT: return to IDLE on the next edge with all reset values. The buffer contents do not matter.
- Buffers are plain registers or LUTRAM with no reset. The block never outputs a buffer slot that was not written in the current operation.

Test Plan (N=2; words in hex, LSW first):
- T≥p: p={00005,00001}; T={00009,00001,00000} → output 00004, 00000. out_last_o on the 2nd word. out_valid_o is 1 cycle after the 3rd input word.
- T<p: p={00005,00001}; T={1FFFF,00000,00000} → output 1FFFF, 00000 (T passthrough).
- T==p: p={00005,00001}; T={00005,00001,00000} → output 00000, 00000.
- Carry word with borrow ripple: p={00005,00001}; T={00000,00000,00001} → output 1FFFB, 1FFFE.
- Backpressure: out_ready_i low for 3 cycles on word 0 → out_data_o and out_valid_o held stable; exactly 2 transfers; busy_o low after the last one. Extra res_valid_i pulse during OUTPUT → overrun_o=1; output unchanged; next start_i clears it.
- reset_i after 2 captured words → IDLE, busy_o=0, out_valid_o=0. The next full operation yields correct results.

Source files
------------

// File: rtl/fios_final_reduce.sv
// Final conditional subtraction for the FIOS Montgomery cascade: captures T word-serially,
// forms T - p on the fly, then streams out either D = T - p or T depending on the final borrow.
module fios_final_reduce #(
    parameter int WIDTH = 17,
    parameter int N     = 16,
    parameter int CW    = $clog2(N + 1)
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             res_valid_i,
    input  logic [WIDTH-1:0] res_i,
    input  logic [WIDTH-1:0] p_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             overrun_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] K_CARRY = CW'(N);
    localparam logic [CW-1:0] K_LAST  = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OUTPUT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_sel_d;
    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_data;
    logic             r_overrun;
    logic [WIDTH-1:0] r_t_buf [N];
    logic [WIDTH-1:0] r_d_buf [N];

    logic             w_is_carry;
    logic [WIDTH-1:0] w_p_eff;
    logic [WIDTH:0]   w_diff;
    logic             w_capture;
    logic             w_done_in;
    logic             w_xfer;
    logic             w_xfer_last;
    logic [CW-1:0]    w_cnt_inc;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_idx_inc;

    // The carry word T[N] is subtracted against an implicit p[N] = 0.
    assign w_is_carry  = (r_cnt == K_CARRY);
    assign w_p_eff     = w_is_carry ? '0 : p_i;
    assign w_diff      = {1'b0, res_i} - {1'b0, w_p_eff} - {{WIDTH{1'b0}}, r_borrow};
    assign w_capture   = (r_state == S_COLLECT) && res_valid_i;
    assign w_done_in   = w_capture && w_is_carry;
    assign w_xfer      = (r_state == S_OUTPUT) && r_out_valid && out_ready_i;
    assign w_xfer_last = w_xfer && (r_cnt == K_LAST);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_idx       = r_cnt[IW-1:0];
    assign w_idx_inc   = w_cnt_inc[IW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start_i)     w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_done_in)   w_state_nxt = S_OUTPUT;
            S_OUTPUT:  if (w_xfer_last) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_cnt       <= '0;
            r_borrow    <= 1'b0;
            r_sel_d     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            // A start in IDLE clears the flag even if a stray word arrives in the same cycle.
            if ((r_state == S_IDLE) && start_i) begin
                r_overrun <= 1'b0;
            end else if (res_valid_i && (r_state != S_COLLECT)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_cnt    <= '0;
                        r_borrow <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (res_valid_i) begin
                        r_borrow <= w_diff[WIDTH];
                        if (w_is_carry) begin
                            r_cnt       <= '0;
                            r_sel_d     <= ~w_diff[WIDTH];
                            r_out_valid <= 1'b1;
                            r_out_last  <= (K_LAST == '0);
                            r_out_data  <= w_diff[WIDTH] ? r_t_buf[0] : r_d_buf[0];
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (w_xfer) begin
                        if (r_cnt == K_LAST) begin
                            r_cnt       <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_cnt      <= w_cnt_inc;
                            r_out_last <= (w_cnt_inc == K_LAST);
                            r_out_data <= r_sel_d ? r_d_buf[w_idx_inc] : r_t_buf[w_idx_inc];
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Result buffers carry no reset; only slots written in the current pass are ever read.
    always_ff @(posedge clock_i) begin
        if (w_capture && !w_is_carry) begin
            r_t_buf[w_idx] <= res_i;
            r_d_buf[w_idx] <= w_diff[WIDTH-1:0];
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_last_o  = r_out_last;
    assign busy_o      = (r_state != S_IDLE);
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_fios_final_reduce.sv
// Directed bench for fios_final_reduce at N=2: vector table plus backpressure, overrun and reset sequences.
module tb_fios_final_reduce;
    localparam int W = 17;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         res_valid;
    logic [W-1:0] res;
    logic [W-1:0] p;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         busy;
    logic         overrun;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string        name;
        logic [W-1:0] p0, p1;
        logic [W-1:0] t0, t1, t2;
        logic [W-1:0] e0, e1;
    } vec_t;

    vec_t vecs [4];

    fios_final_reduce #(.WIDTH(W), .N(N)) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .start_i    (start),
        .res_valid_i(res_valid),
        .res_i      (res),
        .p_i        (p),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_last_o (out_last),
        .busy_o     (busy),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input vec_t v);
        logic [W-1:0] tw [3];
        logic [W-1:0] pw [3];
        tw[0] = v.t0; tw[1] = v.t1; tw[2] = v.t2;
        pw[0] = v.p0; pw[1] = v.p1; pw[2] = '0;
        for (int k = 0; k < 3; k++) begin
            chk({v.name, " valid before capture"}, W'(out_valid), '0);
            res_valid = 1'b1;
            res       = tw[k];
            p         = pw[k];
            tick();
        end
        res_valid = 1'b0;
        chk({v.name, " valid after capture"}, W'(out_valid), W'(1));
        chk({v.name, " word0"}, out_data, v.e0);
        chk({v.name, " last word0"}, W'(out_last), '0);
    endtask

    task automatic drain(input vec_t v);
        out_ready = 1'b1;
        tick();
        chk({v.name, " valid word1"}, W'(out_valid), W'(1));
        chk({v.name, " word1"}, out_data, v.e1);
        chk({v.name, " last word1"}, W'(out_last), W'(1));
        tick();
        out_ready = 1'b0;
        chk({v.name, " valid dropped"}, W'(out_valid), '0);
        chk({v.name, " busy dropped"}, W'(busy), '0);
    endtask

    initial begin
        vecs[0] = '{name:"ge",    p0:17'h00005, p1:17'h00001, t0:17'h00009, t1:17'h00001, t2:17'h00000, e0:17'h00004, e1:17'h00000};
        vecs[1] = '{name:"lt",    p0:17'h00005, p1:17'h00001, t0:17'h1FFFF, t1:17'h00000, t2:17'h00000, e0:17'h1FFFF, e1:17'h00000};
        vecs[2] = '{name:"eq",    p0:17'h00005, p1:17'h00001, t0:17'h00005, t1:17'h00001, t2:17'h00000, e0:17'h00000, e1:17'h00000};
        vecs[3] = '{name:"carry", p0:17'h00005, p1:17'h00001, t0:17'h00000, t1:17'h00000, t2:17'h00001, e0:17'h1FFFB, e1:17'h1FFFE};

        rst = 1'b1; start = 1'b0; res_valid = 1'b0; res = '0; p = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset valid",   W'(out_valid), '0);
        chk("reset data",    out_data, '0);
        chk("reset last",    W'(out_last), '0);
        chk("reset busy",    W'(busy), '0);
        chk("reset overrun", W'(overrun), '0);

        for (int i = 0; i < 4; i++) begin
            do_start();
            chk({vecs[i].name, " busy"}, W'(busy), W'(1));
            feed(vecs[i]);
            drain(vecs[i]);
        end

        // Backpressure on word 0, plus a stray word during OUTPUT.
        do_start();
        feed(vecs[0]);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp hold valid", W'(out_valid), W'(1));
            chk("bp hold data",  out_data, 17'h00004);
        end
        res_valid = 1'b1; res = 17'h12345; p = 17'h00007;
        tick();
        res_valid = 1'b0;
        chk("bp overrun set", W'(overrun), W'(1));
        chk("bp data after stray", out_data, 17'h00004);
        begin
            int xfers;
            xfers = 0;
            out_ready = 1'b1;
            for (int c = 0; c < 6; c++) begin
                if (out_valid && out_ready) xfers++;
                tick();
            end
            out_ready = 1'b0;
            chk("bp transfers", W'(xfers), W'(2));
        end
        chk("bp busy after", W'(busy), '0);
        chk("bp overrun sticky", W'(overrun), W'(1));
        do_start();
        chk("start clears overrun", W'(overrun), '0);
        feed(vecs[2]);
        drain(vecs[2]);

        // Stray word in IDLE sets overrun; start with a simultaneous word clears it and drops the word.
        res_valid = 1'b1; res = 17'h0AAAA; p = 17'h00003;
        tick();
        chk("idle overrun set", W'(overrun), W'(1));
        start = 1'b1;
        tick();
        start = 1'b0; res_valid = 1'b0;
        chk("start wins over word", W'(overrun), '0);
        feed(vecs[1]);
        drain(vecs[1]);

        // Reset in the middle of COLLECT.
        do_start();
        res_valid = 1'b1; res = 17'h00009; p = 17'h00005;
        tick();
        res = 17'h00001; p = 17'h00001;
        tick();
        res_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst busy",  W'(busy), '0);
        chk("midrst valid", W'(out_valid), '0);
        do_start();
        feed(vecs[3]);
        drain(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1);
    end
endmodule
